// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the execute-stage multiply/divide unit: bus widths,
// ALU opcodes, FSM state encodings and a small sign-fixup helper.
package ex_muldiv_pkg;

  localparam int ALUOP_W = 8;
  localparam int REG_W   = 32;

  localparam logic             RST_ENABLE = 1'b1;
  localparam logic [REG_W-1:0] ZERO_WORD  = '0;

  localparam logic [ALUOP_W-1:0] EXE_NOP_OP   = 8'h00;
  localparam logic [ALUOP_W-1:0] EXE_MULT_OP  = 8'h18;
  localparam logic [ALUOP_W-1:0] EXE_MULTU_OP = 8'h19;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP   = 8'h1A;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP  = 8'h1B;
  localparam logic [ALUOP_W-1:0] EXE_MADD_OP  = 8'hA6;
  localparam logic [ALUOP_W-1:0] EXE_MADDU_OP = 8'hA8;
  localparam logic [ALUOP_W-1:0] EXE_MSUB_OP  = 8'hAA;
  localparam logic [ALUOP_W-1:0] EXE_MSUBU_OP = 8'hAB;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DIV_RUN  = 2'd1;
  localparam logic [1:0] ST_DIV_ZERO = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  typedef logic [REG_W-1:0] reg_data_t;

  function automatic reg_data_t neg_if(input logic neg, input reg_data_t v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle over 32 cycles.
// ready is high during the final iteration; results are valid after that edge.
module div_iter
  import ex_muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             annul,
  input  logic [REG_W-1:0] dividend,
  input  logic [REG_W-1:0] divisor,
  output logic [REG_W-1:0] quotient,
  output logic [REG_W-1:0] remainder,
  output logic             ready
);

  logic [5:0]       cnt_reg;
  logic             busy_reg;
  logic [REG_W-1:0] dvd_reg;
  logic [REG_W-1:0] dvs_reg;
  logic [REG_W-1:0] rem_reg;
  logic [REG_W:0]   diff;

  // 33-bit trial subtract; bit 32 set means the shifted remainder was smaller
  assign diff = {rem_reg, dvd_reg[REG_W-1]} - {1'b0, dvs_reg};

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      dvd_reg  <= '0;
      dvs_reg  <= '0;
      rem_reg  <= '0;
    end else if (annul) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
    end else if (start) begin
      cnt_reg  <= '0;
      busy_reg <= 1'b1;
      dvd_reg  <= dividend;
      dvs_reg  <= divisor;
      rem_reg  <= '0;
    end else if (busy_reg) begin
      if (!diff[REG_W]) begin
        rem_reg <= diff[REG_W-1:0];
        dvd_reg <= {dvd_reg[REG_W-2:0], 1'b1};
      end else begin
        rem_reg <= {rem_reg[REG_W-2:0], dvd_reg[REG_W-1]};
        dvd_reg <= {dvd_reg[REG_W-2:0], 1'b0};
      end
      cnt_reg <= cnt_reg + 6'd1;
      if (cnt_reg == 6'd31) busy_reg <= 1'b0;
    end
  end

  assign quotient  = dvd_reg;
  assign remainder = rem_reg;
  assign ready     = busy_reg && (cnt_reg == 6'd31);

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage HI/LO unit: single-cycle MULT/MULTU and a 32-cycle DIV/DIVU FSM.
// Define MULDIV_MADD_EN to add two-cycle MADD/MADDU/MSUB/MSUBU accumulate.
module ex_muldiv
  import ex_muldiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [ALUOP_W-1:0] ex_aluop,
  input  logic [REG_W-1:0]   ex_reg1,
  input  logic [REG_W-1:0]   ex_reg2,
  input  logic [REG_W-1:0]   hi_i,
  input  logic [REG_W-1:0]   lo_i,
  input  logic               annul_i,
  output logic               stallreq_o,
  output logic [REG_W-1:0]   hi_o,
  output logic [REG_W-1:0]   lo_o,
  output logic               hilo_we_o
);

  logic [1:0]       state_reg, state_next;
  logic             quot_neg_reg, rem_neg_reg, zero_reg;
  logic             is_mul, is_div, div_signed, mul_signed;
  logic [63:0]      mul_a, mul_b, product;
  logic [REG_W-1:0] dvd_mag, dvs_mag, div_q, div_r;
  logic             div_start, div_ready;
  logic             stall_c, we_c;
  logic [REG_W-1:0] hi_c, lo_c;

  assign is_mul     = (ex_aluop == EXE_MULT_OP) || (ex_aluop == EXE_MULTU_OP);
  assign is_div     = (ex_aluop == EXE_DIV_OP)  || (ex_aluop == EXE_DIVU_OP);
  assign div_signed = (ex_aluop == EXE_DIV_OP);

`ifdef MULDIV_MADD_EN
  logic        is_madd, madd_load, madd_pend_reg, madd_sub_reg;
  logic [63:0] prod_reg, acc;

  assign is_madd    = (ex_aluop == EXE_MADD_OP) || (ex_aluop == EXE_MADDU_OP) ||
                      (ex_aluop == EXE_MSUB_OP) || (ex_aluop == EXE_MSUBU_OP);
  assign mul_signed = (ex_aluop == EXE_MULT_OP) || (ex_aluop == EXE_MADD_OP) ||
                      (ex_aluop == EXE_MSUB_OP);
  assign acc = madd_sub_reg ? ({hi_i, lo_i} - prod_reg) : ({hi_i, lo_i} + prod_reg);
`else
  assign mul_signed = (ex_aluop == EXE_MULT_OP);
  logic unused_hilo;
  assign unused_hilo = ^{hi_i, lo_i};
`endif

  // Extending to 64 bits first makes a truncated 64x64 product exact for both signednesses
  assign mul_a   = {{32{mul_signed & ex_reg1[31]}}, ex_reg1};
  assign mul_b   = {{32{mul_signed & ex_reg2[31]}}, ex_reg2};
  assign product = mul_a * mul_b;

  assign dvd_mag = neg_if(div_signed & ex_reg1[31], ex_reg1);
  assign dvs_mag = neg_if(div_signed & ex_reg2[31], ex_reg2);

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .annul     (annul_i),
    .dividend  (dvd_mag),
    .divisor   (dvs_mag),
    .quotient  (div_q),
    .remainder (div_r),
    .ready     (div_ready)
  );

  always_comb begin
    state_next = state_reg;
    stall_c    = 1'b0;
    we_c       = 1'b0;
    hi_c       = ZERO_WORD;
    lo_c       = ZERO_WORD;
    div_start  = 1'b0;
`ifdef MULDIV_MADD_EN
    madd_load  = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (is_mul) begin
          we_c         = 1'b1;
          {hi_c, lo_c} = product;
        end else if (is_div) begin
          if (ex_reg2 != ZERO_WORD) begin
            div_start  = 1'b1;
            stall_c    = 1'b1;
            state_next = ST_DIV_RUN;
          end else begin
            state_next = ST_DIV_ZERO;
          end
        end
`ifdef MULDIV_MADD_EN
        else if (is_madd) begin
          if (madd_pend_reg) begin
            we_c         = 1'b1;
            {hi_c, lo_c} = acc;
          end else begin
            stall_c   = 1'b1;
            madd_load = 1'b1;
          end
        end
`endif
      end
      ST_DIV_RUN: begin
        stall_c = 1'b1;
        if (div_ready) state_next = ST_DONE;
      end
      ST_DIV_ZERO: begin
        stall_c    = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        we_c       = 1'b1;
        hi_c       = zero_reg ? ZERO_WORD : neg_if(rem_neg_reg, div_r);
        lo_c       = zero_reg ? ZERO_WORD : neg_if(quot_neg_reg, div_q);
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // A flush overrides everything, including a pending DONE write
    if (annul_i) begin
      state_next = ST_IDLE;
      stall_c    = 1'b0;
      we_c       = 1'b0;
      hi_c       = ZERO_WORD;
      lo_c       = ZERO_WORD;
      div_start  = 1'b0;
`ifdef MULDIV_MADD_EN
      madd_load  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_reg    <= ST_IDLE;
      quot_neg_reg <= 1'b0;
      rem_neg_reg  <= 1'b0;
      zero_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && is_div && !annul_i) begin
        quot_neg_reg <= div_signed & (ex_reg1[31] ^ ex_reg2[31]);
        rem_neg_reg  <= div_signed & ex_reg1[31];
        zero_reg     <= (ex_reg2 == ZERO_WORD);
      end
    end
  end

`ifdef MULDIV_MADD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      madd_pend_reg <= 1'b0;
      madd_sub_reg  <= 1'b0;
      prod_reg      <= '0;
    end else begin
      madd_pend_reg <= madd_load;
      if (madd_load) begin
        prod_reg     <= product;
        madd_sub_reg <= (ex_aluop == EXE_MSUB_OP) || (ex_aluop == EXE_MSUBU_OP);
      end
    end
  end
`endif

  // Reset must silence the outputs at once, even with a live opcode on the inputs
  assign stallreq_o = (rst == RST_ENABLE) ? 1'b0 : stall_c;
  assign hilo_we_o  = (rst == RST_ENABLE) ? 1'b0 : we_c;
  assign hi_o       = (rst == RST_ENABLE) ? ZERO_WORD : hi_c;
  assign lo_o       = (rst == RST_ENABLE) ? ZERO_WORD : lo_c;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed multiply/divide/annul/reset steps
// with a queue scoreboard of expected HI, LO and stall-cycle counts.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ALUOP_W-1:0] ex_aluop = EXE_NOP_OP;
  logic [REG_W-1:0]   ex_reg1 = '0, ex_reg2 = '0, hi_i = '0, lo_i = '0;
  logic               annul_i = 1'b0;
  logic               stallreq_o, hilo_we_o;
  logic [REG_W-1:0]   hi_o, lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .ex_aluop   (ex_aluop),
    .ex_reg1    (ex_reg1),
    .ex_reg2    (ex_reg2),
    .hi_i       (hi_i),
    .lo_i       (lo_i),
    .annul_i    (annul_i),
    .stallreq_o (stallreq_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hilo_we_o  (hilo_we_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] hi, input logic [31:0] lo, input int stalls);
    exp_t e;
    e.hi = hi; e.lo = lo; e.stalls = stalls;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; runs one op until its HI/LO write
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hin, input logic [31:0] lin);
    int   stalls = 0;
    logic got    = 1'b0;
    logic wstall = 1'b0;
    logic [31:0] ohi = '0, olo = '0;
    exp_t e;
    ex_aluop = op; ex_reg1 = a; ex_reg2 = b; hi_i = hin; lo_i = lin;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (hilo_we_o) begin
        got = 1'b1; wstall = stallreq_o; ohi = hi_o; olo = lo_o;
        break;
      end
      if (stallreq_o) stalls++;
      @(posedge clk); #1;
    end
    ex_aluop = EXE_NOP_OP;
    e = sb.pop_front();
    check({tag, "_write_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_hi"}, 64'(ohi), 64'(e.hi));
      check({tag, "_lo"}, 64'(olo), 64'(e.lo));
      check({tag, "_stall_cycles"}, 64'(stalls), 64'(e.stalls));
      check({tag, "_stall_at_write"}, 64'(wstall), 64'd0);
    end
    $display("txn %s op=%02h a=%08h b=%08h hi=%08h lo=%08h stalls=%0d", tag, op, a, b, ohi, olo, stalls);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_single_write"}, 64'(hilo_we_o), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int writes;

    // Reset state, with a divide opcode already presented
    ex_aluop = EXE_DIVU_OP; ex_reg2 = 32'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 64'(stallreq_o), 64'd0);
    check("reset_we", 64'(hilo_we_o), 64'd0);
    check("reset_hi", 64'(hi_o), 64'd0);
    check("reset_lo", 64'(lo_o), 64'd0);
    $display("txn reset stall=%0d we=%0d", stallreq_o, hilo_we_o);
    ex_aluop = EXE_NOP_OP;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    push_exp(32'd2, 32'd14, 33);
    run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, '0, '0);

    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("div_m7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, '0, '0);

    push_exp(32'd2, 32'hFFFF_FFF2, 33);
    run_op("div_100_m7", EXE_DIV_OP, 32'd100, 32'hFFFF_FFF9, '0, '0);

    push_exp(32'd0, 32'd0, 1);
    run_op("div_by_zero", EXE_DIV_OP, 32'd1234, 32'd0, '0, '0);

    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op("mult_m1_2", EXE_MULT_OP, 32'hFFFF_FFFF, 32'd2, '0, '0);

    push_exp(32'h0000_0001, 32'hFFFF_FFFE, 0);
    run_op("multu_ff_2", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, '0, '0);

    // Unrelated opcode: no write, no stall
    ex_aluop = 8'h20; ex_reg1 = 32'd3; ex_reg2 = 32'd4;
    @(negedge clk);
    check("other_op_we", 64'(hilo_we_o), 64'd0);
    check("other_op_stall", 64'(stallreq_o), 64'd0);
    $display("txn other_op we=%0d stall=%0d", hilo_we_o, stallreq_o);

    // Flush suppresses a multiply write
    ex_aluop = EXE_MULT_OP; annul_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("annul_mult_we", 64'(hilo_we_o), 64'd0);
    $display("txn annul_mult we=%0d", hilo_we_o);
    @(posedge clk); #1;
    annul_i = 1'b0; ex_aluop = EXE_NOP_OP;
    @(posedge clk); #1;

    // Annul at iteration 10 of a DIVU
    ex_aluop = EXE_DIVU_OP; ex_reg1 = 32'd1000; ex_reg2 = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    annul_i = 1'b1; ex_aluop = EXE_NOP_OP;
    @(negedge clk);
    check("annul_div_we", 64'(hilo_we_o), 64'd0);
    @(posedge clk); #1;
    annul_i = 1'b0;
    @(negedge clk);
    check("annul_div_idle_stall", 64'(stallreq_o), 64'd0);
    writes = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (hilo_we_o) writes++;
    end
    check("annul_div_no_write", 64'(writes), 64'd0);
    $display("txn annul_divu writes_after=%0d", writes);
    @(posedge clk); #1;

    push_exp(32'd0, 32'd3, 33);
    run_op("divu_9_3", EXE_DIVU_OP, 32'd9, 32'd3, '0, '0);

    // Reset mid-divide
    ex_aluop = EXE_DIVU_OP; ex_reg1 = 32'd1000; ex_reg2 = 32'd7;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_stall", 64'(stallreq_o), 64'd0);
    check("rst_mid_we", 64'(hilo_we_o), 64'd0);
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    $display("txn reset_mid_divide stall=%0d we=%0d", stallreq_o, hilo_we_o);
    ex_aluop = EXE_NOP_OP;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    push_exp(32'd0, 32'd4, 33);
    run_op("divu_8_2", EXE_DIVU_OP, 32'd8, 32'd2, '0, '0);

`ifdef MULDIV_MADD_EN
    push_exp(32'd0, 32'd17, 1);
    run_op("maddu_5_3x4", EXE_MADDU_OP, 32'd3, 32'd4, 32'd0, 32'd5);

    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFF9, 1);
    run_op("msub_5_3x4", EXE_MSUB_OP, 32'd3, 32'd4, 32'd0, 32'd5);

    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1);
    run_op("madd_0_m2x3", EXE_MADD_OP, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0);
`else
    ex_aluop = EXE_MADDU_OP; ex_reg1 = 32'd3; ex_reg2 = 32'd4; hi_i = '0; lo_i = 32'd5;
    writes = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (hilo_we_o || stallreq_o) writes++;
      @(posedge clk); #1;
    end
    check("maddu_disabled_nop", 64'(writes), 64'd0);
    $display("txn maddu_disabled activity=%0d", writes);
    ex_aluop = EXE_NOP_OP;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset (compared against `RstEnable).
REQ-003 SHALL have port ex_aluop, input, `AluOpBus, the operation code presented to the execute stage.
REQ-004 SHALL have ports ex_reg1 and ex_reg2, input, `RegDataBus, operand A (dividend or multiplicand) and operand B (divisor or multiplier).
REQ-005 SHALL have ports hi_i and lo_i, input, `RegDataBus, current forwarded HI and LO values, used for accumulate.
REQ-006 SHALL have port annul_i, input, 1, pipeline flush; aborts any operation in flight.
REQ-007 SHALL have port stallreq_o, output, 1, request to stall PC, IF/ID and ID/EX.
REQ-008 SHALL have ports hi_o and lo_o, output, `RegDataBus, result to be written to HI and LO.
REQ-009 SHALL have port hilo_we_o, output, 1, write strobe for HI/LO; hi_o and lo_o are valid only while it is high.

Function
REQ-010 SHALL implement the FSM states IDLE, DIV_RUN, DIV_ZERO and DONE.
REQ-011 MULT/MULTU: SHALL compute the signed or unsigned 32x32->64 product combinationally and assert hilo_we_o in the same cycle with HI=product[63:32] and LO=product[31:0]; no stall.
REQ-012 DIV/DIVU seen in IDLE with ex_reg2!=0: SHALL latch the operand magnitudes and signs, assert stallreq_o and go to DIV_RUN.
REQ-013 DIV_RUN: SHALL run a restoring divide, one quotient bit per cycle, for 32 cycles counted by a 6-bit counter, with stallreq_o=1; after the 32nd iteration it SHALL go to DONE.
REQ-014 DIV/DIVU seen in IDLE with ex_reg2==0: SHALL go to DIV_ZERO with stallreq_o=1, then to DONE with HI=LO=0.
REQ-015 Signed result: quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend; LO=quotient and HI=remainder.
REQ-016 DONE: hilo_we_o=1 and stallreq_o=0 for exactly one cycle, then return to IDLE; a new divide cannot start until the FSM is back in IDLE.
REQ-017 Divide latency SHALL be 33 stalled cycles (IDLE + 32 iterations) plus one DONE cycle; divide by zero SHALL take 1 stalled cycle plus DONE.
REQ-018 annul_i=1 in any state SHALL force IDLE on the next edge with hilo_we_o=0 that cycle; annul in DONE suppresses the write.
REQ-019 Any other ex_aluop SHALL give hilo_we_o=0 and stallreq_o=0.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, clear the counter and the dividend/divisor/partial-remainder registers, and drive stallreq_o=0, hilo_we_o=0, hi_o=lo_o=`ZeroWord.
REQ-021 Reset mid-divide SHALL discard the operation with no write.

Configuration
REQ-022 With macro MULDIV_MADD_EN defined, the block SHALL support MADD, MADDU, MSUB and MSUBU:
- cycle 0: register the product, stallreq_o=1;
- cycle 1: {HI,LO}={hi_i,lo_i} plus or minus the product modulo 2^64, hilo_we_o=1, stallreq_o=0.
REQ-023 Without MULDIV_MADD_EN, these opcodes SHALL behave as NOP (no stall, no write) and the accumulate state and logic SHALL be absent.

Structure
REQ-024 Opcodes (`EXE_MULT_OP, `EXE_DIV_OP, `EXE_MADD_OP, etc.), bus widths and FSM state encodings SHALL live in the shared consts.vh.
REQ-025 The divider datapath SHALL be a sub-module div_iter (operands, start, annul in; quotient, remainder, ready out); multiply and control stay in ex_muldiv.

Verification
REQ-026 DIVU 100/7 -> stallreq_o high for 33 cycles, then one cycle with hilo_we_o=1, LO=14, HI=2.
REQ-027 DIV 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV by 0 -> 1 stall cycle, then HI=LO=0.
REQ-028 MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE with no stall; MULTU of the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-029 annul_i pulsed at iteration 10 of a DIVU -> IDLE next cycle, no hilo_we_o; a following DIVU 9/3 -> LO=3, HI=0.
REQ-030 rst asserted mid-divide -> all outputs 0 immediately; after release, DIVU 8/2 -> LO=4, HI=0.
REQ-031 With MULDIV_MADD_EN: MADDU with hi_i=0, lo_i=5, operands 3 and 4 -> 1 stall cycle, then LO=17, HI=0; without the macro -> no write.
